// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, parity modes and parity helper.
// Used by the transmitter and intended for reuse by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  // Widest payload any frame can carry; narrower words are zero-extended.
  localparam int MAX_DATA_BITS = 9;

  // Zero-extension does not disturb the XOR, so one helper serves all widths.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] d,
                                      input logic [1:0] mode);
    return (^d) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Byte-source handshake into the UART transmitter.
interface uart_tx_param_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period timer; bit_end marks the last cycle of each bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_q;

  assign bit_end = (cnt_q == LAST);

  // Count 0..CLKS_PER_BIT-1, held at zero while cleared so a new frame starts aligned.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) cnt_q <= '0;
    else if (bit_end)    cnt_q <= '0;
    else                 cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input and optional idle gap.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int IDLE_BITS    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_param_if.slave    bus,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        state
);
  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || IDLE_BITS < 0 || IDLE_BITS > 15) begin : g_bad_param
    $error("uart_tx_param: parameter out of range");
  end

  localparam int             CW        = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]  LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [3:0]     LAST_GAP  = 4'(IDLE_BITS - 1);
  localparam logic [1:0]     PAR_MODE  = 2'(PARITY);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           sub_q, sub_d;    // stop / gap bit-time counter
  logic                 tx_q, tx_d;
  logic                 busy_q;
  logic                 bit_end;
  logic                 timer_clr;

  assign timer_clr = (state_q == ST_IDLE);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clr),
    .bit_end (bit_end)
  );

  assign bus.tx_ready = (state_q == ST_IDLE);
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign state        = state_q;
  assign frame_done   = (state_q == ST_STOP) && (sub_q == LAST_STOP) && bit_end;

  // Next-state and next-bit selection; tx is derived from the next state so it is registered.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    case (state_q)
      ST_IDLE: if (bus.tx_valid) begin
        state_d = ST_START;
        shreg_d = bus.tx_data;
        par_d   = parity_bit(MAX_DATA_BITS'(bus.tx_data), PAR_MODE);
        cnt_d   = '0;
        sub_d   = '0;
      end
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: if (bit_end) begin
        shreg_d = shreg_q >> 1;
        if (cnt_q == LAST_DATA) begin
          cnt_d   = '0;
          sub_d   = '0;
          state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: if (bit_end) begin
        state_d = ST_STOP;
        sub_d   = '0;
      end
      ST_STOP: if (bit_end) begin
        if (sub_q == LAST_STOP) begin
          state_d = (IDLE_BITS != 0) ? ST_GAP : ST_IDLE;
          sub_d   = '0;
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
      ST_GAP: if (bit_end) begin
        if (sub_q == LAST_GAP) state_d = ST_IDLE;
        else                   sub_d   = sub_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      sub_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench: five transmitter configurations, table-driven frames plus corner sequences.
module tb_uart_tx_param;
  localparam int NI  = 5;
  localparam int CPB = 4;
  // Instance configs, index 0 at the right: k0 8N1, k1 8E1, k2 8O1, k3 7N2, k4 8N1 gap 2.
  localparam logic [NI-1:0][3:0] DB = {4'd8, 4'd7, 4'd8, 4'd8, 4'd8};
  localparam logic [NI-1:0][1:0] PB = {2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
  localparam logic [NI-1:0][1:0] SB = {2'd1, 2'd2, 2'd1, 2'd1, 2'd1};
  localparam logic [NI-1:0][3:0] IB = {4'd2, 4'd0, 4'd0, 4'd0, 4'd0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0] valid = '0;
  logic [8:0] data [NI];
  wire  [NI-1:0] ready, txw, busyw, donew;
  wire  [NI-1:0][2:0] stw;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    uart_tx_param_if #(.DATA_BITS(int'(DB[k]))) bus ();
    assign bus.tx_data  = data[k][int'(DB[k])-1:0];
    assign bus.tx_valid = valid[k];
    assign ready[k]     = bus.tx_ready;
    uart_tx_param #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(int'(DB[k])), .PARITY(int'(PB[k])),
      .STOP_BITS(int'(SB[k])), .IDLE_BITS(int'(IB[k]))
    ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave),
      .tx(txw[k]), .busy(busyw[k]), .frame_done(donew[k]), .state(stw[k])
    );
  end

  typedef struct {
    int         k;
    logic [8:0] d;
    string      pat;       // expected tx per bit-time, in time order
    int         done_idx;  // bit index holding frame_done on its last cycle
    string      nm;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Called on a negedge; returns just after the accepting posedge.
  task automatic accept_frame(input int k, input logic [8:0] d);
    int t;
    t = 0;
    while (!ready[k] && t < 500) begin @(negedge clk); t++; end
    if (!ready[k]) chk("wait ready", 0, 1);
    data[k]  = d;
    valid[k] = 1'b1;
    @(posedge clk);
  endtask

  // Called right after the accepting posedge; scrambles tx_data while busy.
  task automatic check_frame(input int k, input string pat, input int done_idx,
                             input int raise_at, input logic [8:0] rd, input string nm);
    int ctl_bad, done_at, done_cnt, n, exp_b, got_b;
    ctl_bad = 0; done_at = -1; done_cnt = 0;
    @(negedge clk);
    valid[k] = 1'b0;
    data[k]  = ~data[k];
    for (int i = 0; i < pat.len(); i++) begin
      exp_b = (pat[i] == "1") ? 1 : 0;
      got_b = exp_b;
      for (int c = 0; c < CPB; c++) begin
        n = i * CPB + c;
        if (n == raise_at) begin valid[k] = 1'b1; data[k] = rd; end
        if (int'(txw[k]) != exp_b) got_b = int'(txw[k]);
        if (donew[k]) begin done_cnt++; done_at = n; end
        if (ready[k] || !busyw[k]) ctl_bad++;
        if (n != pat.len() * CPB - 1) @(negedge clk);
      end
      chk($sformatf("%s tx bit%0d", nm, i), got_b, exp_b);
    end
    chk({nm, " frame_done cycle"}, (done_cnt == 1) ? done_at : -1, done_idx * CPB + CPB - 1);
    chk({nm, " ready/busy in frame"}, ctl_bad, 0);
    @(negedge clk);
    chk({nm, " idle {ready,busy,tx,done}"}, int'({ready[k], busyw[k], txw[k], donew[k]}), 'b1010);
  endtask

  // Holds tx_valid across two frames and measures the accept-to-accept period.
  task automatic b2b(input int k, input int exp_period, input string pat, input string nm);
    int n;
    accept_frame(k, 9'h055);
    @(negedge clk);
    data[k] = 9'h0AA;
    n = 1;
    while (!ready[k] && n < 200) begin @(negedge clk); n++; end
    chk({nm, " accept period"}, n, exp_period);
    chk({nm, " tx in idle cycle"}, int'(txw[k]), 1);
    @(posedge clk);
    check_frame(k, pat, 9, -1, 9'h0, {nm, " 2nd frame"});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    for (int k = 0; k < NI; k++) data[k] = '0;
    tbl.push_back('{0, 9'h0A5, "0101001011",   9,  "8N1 A5"});
    tbl.push_back('{0, 9'h000, "0000000001",   9,  "8N1 00"});
    tbl.push_back('{0, 9'h0FF, "0111111111",   9,  "8N1 FF"});
    tbl.push_back('{1, 9'h0A5, "01010010101",  10, "8E1 A5"});
    tbl.push_back('{1, 9'h001, "01000000011",  10, "8E1 01"});
    tbl.push_back('{2, 9'h0A5, "01010010111",  10, "8O1 A5"});
    tbl.push_back('{2, 9'h000, "00000000011",  10, "8O1 00"});
    tbl.push_back('{3, 9'h0C1, "0100000111",   9,  "7N2 C1"});
    tbl.push_back('{3, 9'h0FF, "0111111111",   9,  "7N2 FF"});
    tbl.push_back('{4, 9'h03C, "000111100111", 9,  "gap2 3C"});

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++)
      chk($sformatf("reset k%0d {tx,busy,done,state}", k),
          int'({txw[k], busyw[k], donew[k], stw[k]}), 'b100000);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk($sformatf("ready after reset k%0d", k), int'(ready[k]), 1);

    foreach (tbl[i]) begin
      accept_frame(tbl[i].k, tbl[i].d);
      check_frame(tbl[i].k, tbl[i].pat, tbl[i].done_idx, -1, 9'h0, tbl[i].nm);
    end

    // Back-to-back with tx_valid held
    b2b(0, 41, "0010101011",   "b2b gap0");
    b2b(4, 49, "001010101111", "b2b gap2");

    // Reset in DATA bit 3 aborts the frame
    accept_frame(0, 9'h000);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre-abort {tx,state}", int'({txw[0], stw[0]}), 'b0010);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort {tx,busy,done,state}", int'({txw[0], busyw[0], donew[0], stw[0]}), 'b100000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort ready after release", int'(ready[0]), 1);
    dn = 0;
    repeat (60) begin @(negedge clk); if (donew[0] || !txw[0]) dn++; end
    chk("abort no done/tx activity", dn, 0);
    accept_frame(0, 9'h05A);
    check_frame(0, "0010110101", 9, -1, 9'h0, "post-abort 5A");

    // tx_valid raised mid-frame waits until IDLE; captured word is what goes out
    accept_frame(0, 9'h00F);
    check_frame(0, "0111100001", 9, 12, 9'h033, "busy 0F");
    @(posedge clk);
    check_frame(0, "0110011001", 9, -1, 9'h0, "queued 33");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
